ring_osc_meter: RTL and testbench
=================================

# ring_osc_meter

Parametrised ring-oscillator frequency meter for the async-cell test chip. It replaces the fixed three-counter byte mux with a multi-channel measurement engine. Each channel's free-running Gray-coded oscillator counter is synchronised into `clk`. The selected ring is enabled for a programmable window of `clk` cycles, and the modular count difference across that window is reported. Host pins start a run, then read the result back byte by byte.

## Interface
- `CHANNELS`, default 3: number of oscillator channels (1–16).
- `CNT_W`, default 24: oscillator counter width in bits.
- `WIN_W`, default 16: width of the window length.
- `SYNC_STAGES`, default 3: synchroniser depth, minimum 2.
- `WARMUP`, default 8: `clk` cycles between ring enable and the start snapshot. Must be ≥ `SYNC_STAGES`+1.

- `clk`, in, 1: measurement clock.
- `reset`, in, 1: reset, asynchronous, active-high; clock `clk`.
- `start`, in, 1: synchronous run request.
- `abort`, in, 1: synchronous cancel.
- `chan_sel`, in, 4: channel for the next run; latched at start.
- `window`, in, `WIN_W`: measurement length in `clk` cycles; latched at start. A value of 0 is treated as 1.
- `byte_sel`, in, 2: result byte to read out.
- `osc_gray`, in, `CHANNELS`×`CNT_W`: async Gray counts from the rings. Channel k occupies bits [k·`CNT_W` +: `CNT_W`].
- `ring_en`, out, `CHANNELS`: one-hot ring enable.
- `busy`, out, 1: run in progress.
- `done`, out, 1: result valid.
- `err`, out, 1: one-cycle pulse when a start is rejected.
- `result_byte`, out, 8: registered byte `byte_sel` of the result. Bits at or above `CNT_W` read as zero.

## Operation
- States: IDLE → WARMUP → MEASURE → COMPUTE → DONE.
- IDLE and DONE accept `start`.
  - `chan_sel` ≥ `CHANNELS`: the start is rejected, `err` pulses, and the state is unchanged.
  - Otherwise: latch `chan_sel`/`window`, set `ring_en[chan]`=1, load the warm-up counter with `WARMUP`−1, clear `done`, and enter WARMUP.
- WARMUP: counter decrements each cycle. At 0, snapshot the synchronised binary count of the channel into `snap0`, load the window counter with `max(window,1)`−1, and enter MEASURE.
- MEASURE: counter decrements each cycle. At 0, snapshot into `snap1`, clear `ring_en`, and enter COMPUTE.
- COMPUTE: `result` = (`snap1` − `snap0`) mod 2^`CNT_W`, which makes counter wrap-around transparent. Set `done`=1 and enter DONE.
- DONE: `done` and `result` are held until the next accepted start.
- Abort:
  - `abort` in WARMUP, MEASURE or COMPUTE returns to IDLE on the next edge with `ring_en`=0, `done`=0, and `result` unchanged.
  - `abort` has priority over a simultaneous `start`.
  - `abort` in IDLE or DONE has no effect.
- `start` while busy is ignored; it does not raise `err`.
- Synchroniser: every channel is synchronised continuously by `SYNC_STAGES` flops, then converted Gray → binary. Snapshot latency is identical at both snapshots, so it cancels.
- Rate constraint: each `osc_gray` must change by at most one code per `clk` cycle. Ring prescaling lives outside this block.
- `busy` = (state ∈ {WARMUP, MEASURE, COMPUTE}).

## Timing
- Reset values:
  - All outputs are 0.
  - `result`, `snap0`, `snap1` and the sync flops are 0.
  - State is IDLE.
- A mid-run reset clears `ring_en` immediately, asynchronously.
- Let E0 be the edge that accepts `start`:
  - `busy` and `ring_en` are high after E0.
  - `snap0` is taken at E`WARMUP`.
  - `snap1` is taken at E(`WARMUP`+W), where W = max(`window`,1).
  - `done` rises after E(`WARMUP`+W+1).
- `err` is high for exactly the cycle after the rejecting edge.
- `result_byte` updates one edge after `byte_sel` or `result` changes.

## Structure
- Package `ring_meter_pkg`: state enum, `gray2bin` function, `MAX_CHANNELS`=16.
- Sub-module `gray_sync_bin`: per-channel `SYNC_STAGES` flop chain followed by Gray→binary conversion, instantiated `CHANNELS` times via generate.
- FSM, counters, subtractor and readout register stay in the top module.

## Test plan
- Channel 1, bench Gray counter advancing once every 2 cycles from 0, `window`=100 → `done` after 8+100+1 cycles, `result`=50, `ring_en`=3'b010 only during the run.
- Channel 0 counter preloaded at 0xFFFFF0, advancing every cycle, `window`=40 → wraps mid-window, `result`=40. `byte_sel`=0 reads 0x28; `byte_sel`=3 reads 0x00.
- `chan_sel`=5 with `CHANNELS`=3 → `err` one-cycle pulse, `busy` stays 0, previous `result` retained.
- `abort` asserted 20 cycles into MEASURE together with `start` → IDLE next cycle, `ring_en`=0, `done`=0, old `result` kept. A fresh start then completes normally.
- `window`=0 → behaves as 1; `done` asserted 10 cycles after start; `result` ≤ 1.
- `reset` pulsed mid-WARMUP → `ring_en`, `busy` and `done` drop asynchronously, all outputs 0, and a new start after release completes with the correct count.

Source files
------------

// File: rtl/ring_meter_pkg.sv
// rtl/ring_meter_pkg.sv - shared types and helpers for the ring oscillator meter
package ring_meter_pkg;
   localparam int MAX_CHANNELS = 16;
   localparam int GRAY_W       = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WARMUP,
      ST_MEASURE,
      ST_COMPUTE,
      ST_DONE
   } state_t;

   // Counts narrower than GRAY_W are zero-extended; leading zeros convert to zeros.
   function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] i_g);
      logic [GRAY_W-1:0] v_b;
      v_b[GRAY_W-1] = i_g[GRAY_W-1];
      for (int i = GRAY_W - 2; i >= 0; i--) begin
         v_b[i] = v_b[i+1] ^ i_g[i];
      end
      return v_b;
   endfunction
endpackage

// File: rtl/ring_osc_meter_gray_sync_bin.sv
// rtl/ring_osc_meter_gray_sync_bin.sv - synchronise one Gray-coded ring count into clk and convert to binary
module gray_sync_bin
   import ring_meter_pkg::*;
#(
   parameter int CNT_W       = 24,
   parameter int SYNC_STAGES = 3
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [CNT_W-1:0] i_gray,
   output logic [CNT_W-1:0] o_bin
);
   logic [CNT_W-1:0]  r_sync [SYNC_STAGES];
   logic [GRAY_W-1:0] w_bin_full;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      end else begin
         r_sync[0] <= i_gray;
         for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      end
   end

   assign w_bin_full = gray2bin(GRAY_W'(r_sync[SYNC_STAGES-1]));
   assign o_bin      = w_bin_full[CNT_W-1:0];
endmodule

// File: rtl/ring_osc_meter.sv
// rtl/ring_osc_meter.sv - multi-channel ring oscillator frequency meter
// Enables one ring for a window of clk cycles and reports the modular count difference.
module ring_osc_meter
   import ring_meter_pkg::*;
#(
   parameter int CHANNELS    = 3,
   parameter int CNT_W       = 24,
   parameter int WIN_W       = 16,
   parameter int SYNC_STAGES = 3,
   parameter int WARMUP      = 8
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_start,
   input  logic                      i_abort,
   input  logic [3:0]                i_chan_sel,
   input  logic [WIN_W-1:0]          i_window,
   input  logic [1:0]                i_byte_sel,
   input  logic [CHANNELS*CNT_W-1:0] i_osc_gray,
   output logic [CHANNELS-1:0]       o_ring_en,
   output logic                      o_busy,
   output logic                      o_done,
   output logic                      o_err,
   output logic [7:0]                o_result_byte
);
   localparam int         CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int         CW       = (WIN_W > $clog2(WARMUP + 1)) ? WIN_W : $clog2(WARMUP + 1);
   localparam logic [4:0] CH_LIMIT = 5'(CHANNELS);

   state_t              r_state, w_next;
   logic [CHW-1:0]      r_chan;
   logic [WIN_W-1:0]    r_win;
   logic [CW-1:0]       r_cnt;
   logic [CNT_W-1:0]    r_snap0, r_snap1, r_result;
   logic                r_done, r_err;
   logic [CHANNELS-1:0] r_ring_en;
   logic [7:0]          r_result_byte;

   logic [CNT_W-1:0]    w_bin [CHANNELS];
   logic [CNT_W-1:0]    w_sel_bin;
   logic [CHANNELS-1:0] w_onehot;
   logic                w_can_start, w_chan_ok, w_accept, w_reject, w_abort, w_cnt_zero;
   logic [31:0]         w_res_ext;

   generate
      for (genvar k = 0; k < CHANNELS; k++) begin : g_sync
         gray_sync_bin #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) u_sync (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_gray  (i_osc_gray[k*CNT_W +: CNT_W]),
            .o_bin   (w_bin[k])
         );
      end
   endgenerate

   always_comb begin
      w_sel_bin = '0;
      w_onehot  = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (r_chan == CHW'(k)) w_sel_bin = w_bin[k];
         w_onehot[k] = (i_chan_sel == 4'(k));
      end
   end

   assign o_busy      = (r_state == ST_WARMUP) || (r_state == ST_MEASURE) || (r_state == ST_COMPUTE);
   assign w_can_start = (r_state == ST_IDLE) || (r_state == ST_DONE);
   assign w_chan_ok   = ({1'b0, i_chan_sel} < CH_LIMIT);
   assign w_accept    = i_start && w_can_start && w_chan_ok;
   assign w_reject    = i_start && w_can_start && !w_chan_ok;
   assign w_abort     = i_abort && o_busy;
   assign w_cnt_zero  = (r_cnt == '0);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= ST_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: if (w_accept) w_next = ST_WARMUP;
         ST_WARMUP:        w_next = w_abort ? ST_IDLE : (w_cnt_zero ? ST_MEASURE : ST_WARMUP);
         ST_MEASURE:       w_next = w_abort ? ST_IDLE : (w_cnt_zero ? ST_COMPUTE : ST_MEASURE);
         ST_COMPUTE:       w_next = w_abort ? ST_IDLE : ST_DONE;
         default:          w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_chan    <= '0;
         r_win     <= '0;
         r_cnt     <= '0;
         r_snap0   <= '0;
         r_snap1   <= '0;
         r_result  <= '0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_ring_en <= '0;
      end else begin
         r_err <= w_reject;
         if (w_abort) begin
            r_ring_en <= '0;
            r_done    <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE, ST_DONE: begin
                  if (w_accept) begin
                     r_chan    <= i_chan_sel[CHW-1:0];
                     // Window length is stored minus one; zero is clamped to a single cycle.
                     r_win     <= (i_window == '0) ? '0 : i_window - WIN_W'(1);
                     r_ring_en <= w_onehot;
                     r_cnt     <= CW'(WARMUP - 1);
                     r_done    <= 1'b0;
                  end
               end
               ST_WARMUP: begin
                  if (w_cnt_zero) begin
                     r_snap0 <= w_sel_bin;
                     r_cnt   <= CW'(r_win);
                  end else begin
                     r_cnt <= r_cnt - CW'(1);
                  end
               end
               ST_MEASURE: begin
                  if (w_cnt_zero) begin
                     r_snap1   <= w_sel_bin;
                     r_ring_en <= '0;
                  end else begin
                     r_cnt <= r_cnt - CW'(1);
                  end
               end
               ST_COMPUTE: begin
                  r_result <= r_snap1 - r_snap0;
                  r_done   <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign w_res_ext = 32'(r_result);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_result_byte <= '0;
      else         r_result_byte <= w_res_ext[{i_byte_sel, 3'b000} +: 8];
   end

   assign o_ring_en     = r_ring_en;
   assign o_done        = r_done;
   assign o_err         = r_err;
   assign o_result_byte = r_result_byte;
endmodule

// File: tb/tb_ring_osc_meter.sv
// tb/tb_ring_osc_meter.sv - directed self-checking bench for ring_osc_meter
module tb_ring_osc_meter;
   localparam int CHANNELS = 3;
   localparam int CNT_W    = 24;
   localparam int WIN_W    = 16;
   localparam int WARMUP   = 8;

   logic                      clk = 1'b0;
   logic                      reset = 1'b1;
   logic                      start = 1'b0;
   logic                      abort = 1'b0;
   logic [3:0]                chan_sel = '0;
   logic [WIN_W-1:0]          window = '0;
   logic [1:0]                byte_sel = '0;
   logic [CHANNELS*CNT_W-1:0] osc_gray;
   logic [CHANNELS-1:0]       ring_en;
   logic                      busy, done, err;
   logic [7:0]                result_byte;

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;
   int base [CHANNELS];
   int t0   [CHANNELS];
   int div  [CHANNELS];
   int k;

   ring_osc_meter #(.CHANNELS(CHANNELS), .CNT_W(CNT_W), .WIN_W(WIN_W),
                    .SYNC_STAGES(3), .WARMUP(WARMUP)) dut (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_start       (start),
      .i_abort       (abort),
      .i_chan_sel    (chan_sel),
      .i_window      (window),
      .i_byte_sel    (byte_sel),
      .i_osc_gray    (osc_gray),
      .o_ring_en     (ring_en),
      .o_busy        (busy),
      .o_done        (done),
      .o_err         (err),
      .o_result_byte (result_byte)
   );

   always #5 clk = ~clk;
   always @(negedge clk) cyc++;

   // Ring models: value = base + elapsed/div (div 0 = stopped), presented as Gray.
   always_comb begin
      osc_gray = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         logic [31:0] v;
         v = 32'(base[c]) + ((div[c] == 0) ? 32'd0 : 32'((cyc - t0[c]) / div[c]));
         osc_gray[c*CNT_W +: CNT_W] = v[CNT_W-1:0] ^ (v[CNT_W-1:0] >> 1);
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
   endtask

   task automatic set_ring(input int c, input int b, input int d);
      base[c] = b;
      t0[c]   = cyc;
      div[c]  = d;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic kick(input int c, input int w);
      chan_sel = 4'(c);
      window   = WIN_W'(w);
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
   endtask

   task automatic wait_done(output int edges);
      edges = 0;
      while (!done && edges < 400) begin
         @(negedge clk);
         edges++;
      end
   endtask

   task automatic read_byte(input string tag, input int sel, input int exp);
      byte_sel = 2'(sel);
      @(negedge clk);
      check(tag, 32'(result_byte), 32'(exp));
   endtask

   initial begin
      for (int c = 0; c < CHANNELS; c++) begin
         base[c] = 0; t0[c] = 0; div[c] = 0;
      end
      idle(2);
      check("reset_ring_en", 32'(ring_en), 0);
      check("reset_busy", 32'(busy), 0);
      check("reset_done", 32'(done), 0);
      check("reset_err", 32'(err), 0);
      check("reset_byte", 32'(result_byte), 0);
      reset = 1'b0;
      idle(2);

      // Channel 1 at half rate, 100-cycle window
      set_ring(1, 0, 2);
      idle(6);
      kick(1, 100);
      check("t1_busy", 32'(busy), 1);
      check("t1_ring_en", 32'(ring_en), 32'h2);
      idle(50);
      check("t1_ring_en_mid", 32'(ring_en), 32'h2);
      wait_done(k);
      check("t1_done_cycle", 32'(k + 50), 32'(WARMUP + 100 + 1));
      check("t1_ring_off", 32'(ring_en), 0);
      check("t1_busy_off", 32'(busy), 0);
      read_byte("t1_byte0", 0, 50);
      read_byte("t1_byte1", 1, 0);

      // Channel 0 wrapping through 2^24 mid-window
      set_ring(0, 32'hFFFFF0, 1);
      idle(4);
      kick(0, 40);
      check("t2_ring_en", 32'(ring_en), 32'h1);
      wait_done(k);
      check("t2_done_cycle", 32'(k), 32'(WARMUP + 40 + 1));
      read_byte("t2_byte0", 0, 8'h28);
      read_byte("t2_byte3", 3, 8'h00);
      read_byte("t2_byte2", 2, 8'h00);

      // Illegal channel rejected from DONE
      kick(5, 10);
      check("t3_err", 32'(err), 1);
      check("t3_busy", 32'(busy), 0);
      check("t3_done_kept", 32'(done), 1);
      @(negedge clk);
      check("t3_err_pulse", 32'(err), 0);
      read_byte("t3_result_kept", 0, 8'h28);

      // Abort with simultaneous start, 20 cycles into MEASURE
      set_ring(2, 1000, 1);
      idle(4);
      kick(2, 100);
      idle(WARMUP + 20 - 1);
      check("t4_busy_before", 32'(busy), 1);
      abort = 1'b1;
      start = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      start = 1'b0;
      check("t4_busy", 32'(busy), 0);
      check("t4_ring_en", 32'(ring_en), 0);
      check("t4_done", 32'(done), 0);
      read_byte("t4_result_kept", 0, 8'h28);
      kick(2, 30);
      wait_done(k);
      check("t4_done_cycle", 32'(k), 32'(WARMUP + 30 + 1));
      read_byte("t4_result", 0, 30);

      // Zero window behaves as one cycle
      kick(0, 0);
      wait_done(k);
      check("t5_done_cycle", 32'(k), 32'(WARMUP + 1 + 1));
      read_byte("t5_result", 0, 1);

      // Reset in the middle of WARMUP
      set_ring(1, 77, 1);
      idle(4);
      kick(1, 20);
      idle(3);
      reset = 1'b1;
      #1;
      check("t6_ring_en", 32'(ring_en), 0);
      check("t6_busy", 32'(busy), 0);
      check("t6_done", 32'(done), 0);
      check("t6_byte", 32'(result_byte), 0);
      @(negedge clk);
      reset = 1'b0;
      idle(5);
      kick(1, 20);
      check("t6_ring_en_run", 32'(ring_en), 32'h2);
      wait_done(k);
      check("t6_done_cycle", 32'(k), 32'(WARMUP + 20 + 1));
      read_byte("t6_result", 0, 20);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
